// File: rtl/regfile_param.sv
// regfile_param: parameterised register file, two read ports, two write ports,
// per-register pending (scoreboard) bits.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; depth is 2**ADDR_W
//   ZERO_REG  1 = register 0 reads zero and ignores writes and pend_set
//   BYPASS    1 = a write in progress is forwarded to a matching read port
//
// Ports
//   clk                          clock, all state changes on the rising edge
//   rst_n                        asynchronous active-low reset
//   read_reg1/2   -> read_data1/2, pend1/2   combinational read ports
//   regWrite_a/b, write_reg_a/b, write_data_a/b   write ports (B wins on collision)
//   pend_set, pend_reg           mark a register as awaiting a result
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              regWrite_a,
    input  logic              regWrite_b,
    input  logic [ADDR_W-1:0] write_reg_a,
    input  logic [ADDR_W-1:0] write_reg_b,
    input  logic [DATA_W-1:0] write_data_a,
    input  logic [DATA_W-1:0] write_data_b,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_reg,
    output logic              pend1,
    output logic              pend2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_next;

    logic we_a;
    logic we_b;
    logic pset;
    logic fwd_a1;
    logic fwd_b1;
    logic fwd_a2;
    logic fwd_b2;

    // Writes and pend marks aimed at a hardwired zero register are dropped
    // here, so nothing downstream (storage, forwarding, pending) sees them.
    assign we_a = regWrite_a && !((ZERO_REG != 0) && (write_reg_a == '0));
    assign we_b = regWrite_b && !((ZERO_REG != 0) && (write_reg_b == '0));
    assign pset = pend_set   && !((ZERO_REG != 0) && (pend_reg    == '0));

    assign fwd_a1 = (BYPASS != 0) && we_a && (write_reg_a == read_reg1);
    assign fwd_b1 = (BYPASS != 0) && we_b && (write_reg_b == read_reg1);
    assign fwd_a2 = (BYPASS != 0) && we_a && (write_reg_a == read_reg2);
    assign fwd_b2 = (BYPASS != 0) && we_b && (write_reg_b == read_reg2);

    // A write retires the pending mark; a pend_set on the same edge wins
    // because it names a newer producer for that register.
    always_comb begin
        pend_next = pend_q;
        if (we_a) pend_next[write_reg_a] = 1'b0;
        if (we_b) pend_next[write_reg_b] = 1'b0;
        if (pset) pend_next[pend_reg]    = 1'b1;
    end

    // Port B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (we_a) mem[write_reg_a] <= write_data_a;
            if (we_b) mem[write_reg_b] <= write_data_b;
            pend_q <= pend_next;
        end
    end

    always_comb begin
        read_data1 = '0;
        pend1      = 1'b0;
        if (rst_n) begin
            if (fwd_b1) begin
                read_data1 = write_data_b;
            end else if (fwd_a1) begin
                read_data1 = write_data_a;
            end else if (!((ZERO_REG != 0) && (read_reg1 == '0))) begin
                read_data1 = mem[read_reg1];
            end
            pend1 = pend_q[read_reg1] && !(fwd_a1 || fwd_b1);
        end
    end

    always_comb begin
        read_data2 = '0;
        pend2      = 1'b0;
        if (rst_n) begin
            if (fwd_b2) begin
                read_data2 = write_data_b;
            end else if (fwd_a2) begin
                read_data2 = write_data_a;
            end else if (!((ZERO_REG != 0) && (read_reg2 == '0))) begin
                read_data2 = mem[read_reg2];
            end
            pend2 = pend_q[read_reg2] && !(fwd_a2 || fwd_b2);
        end
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0, 1 = register 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports read_reg1, read_reg2  input  ADDR_W  read addresses.
REQ-008 SHALL have ports read_data1, read_data2  output  DATA_W  read data.
REQ-009 SHALL have ports regWrite_a, regWrite_b  input  1  write enables, ports A and B.
REQ-010 SHALL have ports write_reg_a, write_reg_b  input  ADDR_W  write addresses.
REQ-011 SHALL have ports write_data_a, write_data_b  input  DATA_W  write data.
REQ-012 SHALL have port pend_set  input  1  mark register pend_reg as awaiting a result.
REQ-013 SHALL have port pend_reg  input  ADDR_W  register to mark pending.
REQ-014 SHALL have ports pend1, pend2  output  1  pending status of read_reg1 and read_reg2.

Function
REQ-015 SHALL write write_data_x into register write_reg_x on the rising clk edge when regWrite_x=1.
REQ-016 SHALL resolve a same-edge, same-address write from both ports in favour of port B; port A's write is dropped.
REQ-017 SHALL read combinationally, with zero-cycle latency from the stored array.
REQ-018 SHALL, when BYPASS=1 and regWrite_x=1 with write_reg_x equal to a read address, drive that read output with write_data_x in the same cycle; B takes precedence over A.
REQ-019 SHALL, when BYPASS=0, return only the stored value; new data is visible the cycle after the edge.
REQ-020 SHALL, when ZERO_REG=1, ignore writes to register 0, read 0 from it, and never forward to it or mark it pending.
REQ-021 SHALL hold one pending bit per register; pend_set=1 sets bit pend_reg on the rising edge.
REQ-022 SHALL clear a register's pending bit on the edge where either write port writes it.
REQ-023 SHALL leave the bit set when pend_set and a write target the same register on the same edge, because the new producer wins.
REQ-024 SHALL drive pend1/pend2 as the pending bit of the addressed register.
REQ-025 SHALL, when BYPASS=1, drive pend1/pend2 to 0 while a same-cycle write to that address is being forwarded.
REQ-026 SHALL let both read ports address the same register and return identical data and pend values.
REQ-027 SHALL support all addresses 0..2**ADDR_W-1 with no wrap-around or aliasing; address 2**ADDR_W-1 is a normal register.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear every register and pending bit to 0, independent of clk.
REQ-029 SHALL, while rst_n=0, ignore writes and pend_set and suppress forwarding; read_data1/2=0 and pend1/2=0.
REQ-030 SHALL take effect immediately if rst_n is asserted mid-operation, with no partial write surviving.
REQ-031 SHALL honour the first write on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL pass, with defaults: write A r0=0x0001, then r1=0x0002 on separate edges, read r0/r1 -> 0x0001/0x0002.
REQ-033 SHALL pass: same edge A writes r5=0x1111, B writes r5=0x2222 -> r5 reads 0x2222 afterwards; read_reg1=5 in that cycle forwards 0x2222 (BYPASS=1), or the old value (BYPASS=0).
REQ-034 SHALL pass: pend_set r3 -> pend1=1 for read_reg1=3 next cycle; write r3=0x00AA -> pend1=0 in that cycle (bypass) and after the edge; pend_set+write r3 on one edge -> pend remains 1.
REQ-035 SHALL pass, with ZERO_REG=1: write r0=0xFFFF, pend_set r0 -> read 0x0000, pend 0.
REQ-036 SHALL pass, with DATA_W=32, ADDR_W=5: write r31=0xDEADBEEF -> read 0xDEADBEEF; r0 is unaffected.
REQ-037 SHALL pass: fill registers, assert rst_n=0 between edges -> outputs 0 immediately; writes during reset are ignored; after release all reads are 0.
